// File: rtl/pulse_sync_pkg.sv
// rtl/pulse_sync_pkg.sv - shared types and defaults for the pulse synchronizer blocks
package pulse_sync_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } hs_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop bit synchronizer for a single asynchronous level
import pulse_sync_pkg::*;

module sync_ff #(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else begin
            r_shift <= {r_shift[STAGES-2:0], d};
        end
    end

    assign q = r_shift[STAGES-1];

endmodule

// File: rtl/pulse_handshake_src.sv
// rtl/pulse_handshake_src.sv - request end of a two-phase toggle handshake carrying pulses across domains
import pulse_sync_pkg::*;

module pulse_handshake_src #(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             ack_async,
    output logic             req_toggle,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             ack_err
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    hs_state_t        r_state;
    hs_state_t        w_state_next;
    logic             r_req;
    logic             r_overflow;
    logic             r_ack_err;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] w_pending_next;
    logic             w_ack_sync;
    logic             w_aligned;
    logic             w_issue;
    logic             w_dec;
    logic             w_inc;
    logic             w_overflow_set;
    logic             w_ack_err_set;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_async),
        .q   (w_ack_sync)
    );

    assign w_aligned = (w_ack_sync == r_req);

    // A misaligned ack while idle blocks issuing until the destination realigns.
    always_comb begin
        w_state_next  = r_state;
        w_issue       = 1'b0;
        w_ack_err_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_aligned) begin
                    w_ack_err_set = 1'b1;
                end else if ((r_pending != '0) || pulse_in) begin
                    w_issue      = 1'b1;
                    w_state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (w_aligned) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A pulse issued straight from an empty queue never enters the counter.
    assign w_dec = w_issue && (r_pending != '0);
    assign w_inc = pulse_in && !(w_issue && (r_pending == '0));

    always_comb begin
        w_pending_next = r_pending;
        w_overflow_set = 1'b0;
        if (w_inc && !w_dec) begin
            if (r_pending == PEND_MAX) begin
                w_overflow_set = 1'b1;
            end else begin
                w_pending_next = r_pending + 1'b1;
            end
        end else if (!w_inc && w_dec) begin
            w_pending_next = r_pending - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            if (w_issue) begin
                r_req <= ~r_req;
            end
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end
            if (w_ack_err_set) begin
                r_ack_err <= 1'b1;
            end
        end
    end

    assign req_toggle = r_req;
    assign busy       = (r_state == WAIT_ACK);
    assign pending    = r_pending;
    assign overflow   = r_overflow;
    assign ack_err    = r_ack_err;

endmodule

// File: tb/tb_pulse_handshake_src.sv
// tb/tb_pulse_handshake_src.sv - randomized and directed bench for pulse_handshake_src
module tb_pulse_handshake_src;

    localparam int SYNC = 2;
    localparam int CW   = 2;
    localparam int PMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pulse_in;
    logic          ack_async;
    logic          req_toggle;
    logic          busy;
    logic [CW-1:0] pending;
    logic          overflow;
    logic          ack_err;

    int checks = 0;
    int errors = 0;
    int cyc;
    int flips;
    logic prev_req;

    // Reference model: pulses are tracked as counts of accepted, issued and queued events.
    int m_backlog;
    int m_issued;
    bit m_busy;
    bit m_ovf;
    bit m_ackerr;
    bit m_ackq[$];

    // Destination model: returns the req level after a delay of dest_min..dest_max clocks.
    bit   dest_en;
    int   dest_min;
    int   dest_max;
    logic dest_last;
    int   dest_cnt;

    pulse_handshake_src #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (pulse_in),
        .ack_async  (ack_async),
        .req_toggle (req_toggle),
        .busy       (busy),
        .pending    (pending),
        .overflow   (overflow),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_backlog = 0;
        m_issued  = 0;
        m_busy    = 0;
        m_ovf     = 0;
        m_ackerr  = 0;
        m_ackq.delete();
        for (int i = 0; i < SYNC; i++) m_ackq.push_back(1'b0);
    endtask

    task automatic model_accept();
        if (m_backlog < PMAX) m_backlog++;
        else m_ovf = 1;
    endtask

    task automatic model_edge(input bit p, input bit a);
        bit seen;
        bit par;
        seen = m_ackq.pop_front();
        m_ackq.push_back(a);
        par = (m_issued % 2) == 1;
        if (m_busy) begin
            if (seen == par) m_busy = 0;
            if (p) model_accept();
        end else if (seen != par) begin
            m_ackerr = 1;
            if (p) model_accept();
        end else if (m_backlog > 0) begin
            m_issued++;
            m_busy = 1;
            m_backlog--;
            if (p) model_accept();
        end else if (p) begin
            m_issued++;
            m_busy = 1;
        end
    endtask

    task automatic step(input bit p, input bit r);
        bit a;
        logic e_req;
        logic e_busy;
        logic e_ovf;
        logic e_err;
        logic [CW-1:0] e_pend;
        pulse_in = p;
        rst      = r;
        @(posedge clk);
        a = ack_async;
        cyc++;
        if (r) model_reset();
        else model_edge(p, a);
        #1;
        e_req  = (m_issued % 2) == 1;
        e_busy = m_busy;
        e_ovf  = m_ovf;
        e_err  = m_ackerr;
        e_pend = m_backlog[CW-1:0];
        checks++;
        if (req_toggle !== e_req) begin
            errors++;
            $display("FAIL model_req cyc=%0d got=%b exp=%b", cyc, req_toggle, e_req);
        end
        checks++;
        if (busy !== e_busy) begin
            errors++;
            $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
        end
        checks++;
        if (pending !== e_pend) begin
            errors++;
            $display("FAIL model_pending cyc=%0d got=%0d exp=%0d", cyc, pending, e_pend);
        end
        checks++;
        if (overflow !== e_ovf) begin
            errors++;
            $display("FAIL model_overflow cyc=%0d got=%b exp=%b", cyc, overflow, e_ovf);
        end
        checks++;
        if (ack_err !== e_err) begin
            errors++;
            $display("FAIL model_ack_err cyc=%0d got=%b exp=%b", cyc, ack_err, e_err);
        end
        if (!r && (req_toggle !== prev_req)) flips++;
        prev_req = req_toggle;
        if (r) begin
            dest_last = 1'b0;
            dest_cnt  = 0;
            ack_async = 1'b0;
        end else if (dest_en) begin
            if (req_toggle !== dest_last) begin
                dest_last = req_toggle;
                dest_cnt  = $urandom_range(dest_max, dest_min) - 1;
            end else if (dest_cnt > 0) begin
                dest_cnt--;
                if (dest_cnt == 0) ack_async = dest_last;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        cyc   = 0;
        flips = 0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req_toggle, busy, pending, overflow, ack_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {req_toggle, busy, pending, overflow, ack_err});
        end
        run_idle(20);
        checks++;
        if ({req_toggle, busy, pending, overflow, ack_err} !== '0 || flips != 0) begin
            errors++;
            $display("FAIL reset_idle20 got=%b flips=%0d exp=0", {req_toggle, busy, pending, overflow, ack_err}, flips);
        end
    endtask

    task automatic test_single_pulse();
        do_reset();
        run_idle(9);
        step(1'b1, 1'b0);
        checks++;
        if (req_toggle !== 1'b1 || busy !== 1'b1 || pending !== '0) begin
            errors++;
            $display("FAIL single_issue req=%b busy=%b pending=%0d exp req=1 busy=1 pending=0", req_toggle, busy, pending);
        end
        run_idle(7);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_held cyc=%0d got=%b exp=1", cyc, busy);
        end
        step(1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_clear cyc=%0d got=%b exp=0", cyc, busy);
        end
        run_idle(10);
        checks++;
        if (flips != 1) begin
            errors++;
            $display("FAIL single_flips got=%0d exp=1", flips);
        end
    endtask

    task automatic test_back_to_back(input int npulses);
        do_reset();
        run_idle(9);
        step(1'b1, 1'b0);
        checks++;
        if (req_toggle !== 1'b1 || pending !== '0) begin
            errors++;
            $display("FAIL burst_first req=%b pending=%0d exp req=1 pending=0", req_toggle, pending);
        end
        for (int i = 1; i < npulses; i++) begin
            logic [CW-1:0] exp_p;
            exp_p = (i > PMAX) ? CW'(PMAX) : CW'(i);
            step(1'b1, 1'b0);
            checks++;
            if (pending !== exp_p) begin
                errors++;
                $display("FAIL burst_pending cyc=%0d got=%0d exp=%0d", cyc, pending, exp_p);
            end
        end
        checks++;
        if (overflow !== (npulses > PMAX + 1)) begin
            errors++;
            $display("FAIL burst_overflow n=%0d got=%b exp=%b", npulses, overflow, npulses > PMAX + 1);
        end
        run_idle(80);
        checks++;
        if (flips != PMAX + 1 || pending !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_drain n=%0d flips=%0d pending=%0d busy=%b exp flips=%0d pending=0 busy=0",
                     npulses, flips, pending, busy, PMAX + 1);
        end
    endtask

    task automatic test_ack_err();
        do_reset();
        dest_en = 0;
        run_idle(29);
        ack_async = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (ack_err !== 1'b0) begin
            errors++;
            $display("FAIL ack_err_early cyc=%0d got=%b exp=0", cyc, ack_err);
        end
        step(1'b0, 1'b0);
        checks++;
        if (ack_err !== 1'b1 || req_toggle !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_err_set cyc=%0d err=%b req=%b busy=%b exp err=1 req=0 busy=0", cyc, ack_err, req_toggle, busy);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run_idle(3);
        checks++;
        if (req_toggle !== 1'b0 || flips != 0) begin
            errors++;
            $display("FAIL ack_err_blocked req=%b flips=%0d exp req=0 flips=0", req_toggle, flips);
        end
        dest_en = 1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_idle(9);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        checks++;
        if ({req_toggle, busy, pending, overflow, ack_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%b exp=0", {req_toggle, busy, pending, overflow, ack_err});
        end
        flips = 0;
        run_idle(20);
        checks++;
        if (flips != 0 || req_toggle !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet flips=%0d req=%b exp flips=0 req=0", flips, req_toggle);
        end
    endtask

    task automatic test_random();
        int density [3] = '{15, 45, 90};
        dest_min = 2;
        dest_max = 9;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                step($urandom_range(99) < density[r], $urandom_range(199) == 0);
            end
            run_idle(100);
            checks++;
            if (pending !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL random_drain round=%0d pending=%0d busy=%b exp pending=0 busy=0", r, pending, busy);
            end
        end
        dest_min = 6;
        dest_max = 6;
    endtask

    initial begin
        rst       = 1'b1;
        pulse_in  = 1'b0;
        ack_async = 1'b0;
        dest_en   = 1;
        dest_min  = 6;
        dest_max  = 6;
        dest_last = 1'b0;
        dest_cnt  = 0;
        prev_req  = 1'b0;
        cyc       = 0;
        flips     = 0;
        model_reset();
        test_reset();
        test_single_pulse();
        test_back_to_back(4);
        test_back_to_back(5);
        test_ack_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
